// File: rtl/pitch_ola_writer_pkg.sv
// Shared PitchCore definitions: SDRAM/sample widths, saturation limits and
// the overlap-add writer state encoding.
package PitchDefine;

  localparam int PITCH_ADDR_W = 23;
  localparam int SAMPLE_W     = 16;
  localparam int SDRAM_DATA_W = 32;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SAMPLE = 3'd1,
    READ        = 3'd2,
    WRITE       = 3'd3,
    DONE        = 3'd4
  } ola_state_t;

endpackage

// File: rtl/pitch_ola_writer_sat_add16.sv
// Combinational signed 16+16 add, clamped to the 16-bit signed range.
module sat_add16
  import PitchDefine::*;
(
  input  logic signed [SAMPLE_W-1:0] a_i,
  input  logic signed [SAMPLE_W-1:0] b_i,
  output logic signed [SAMPLE_W-1:0] sum_o
);

  logic [SAMPLE_W:0] wide;

  always_comb begin
    wide = {a_i[SAMPLE_W-1], a_i} + {b_i[SAMPLE_W-1], b_i};
    // The two top bits disagree only when the 17-bit sum left the 16-bit range.
    if (wide[SAMPLE_W] != wide[SAMPLE_W-1]) begin
      sum_o = wide[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = wide[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/pitch_ola_writer.sv
// Overlap-add writeback: read-modify-write of one windowed frame into SDRAM,
// adding each sample to both stereo channels with saturation.
//
// state       | meaning
// IDLE        | waiting for ola_start
// WAIT_SAMPLE | s_ready high, waiting for the next windowed sample
// READ        | SDRAM read of the target word outstanding
// WRITE       | SDRAM write of the summed (or overwritten) word outstanding
// DONE        | one-cycle frame completion pulse
module pitch_ola_writer
  import PitchDefine::*;
#(
  parameter int WINDOW_SIZE = 1024,
  parameter int ADDR_W      = PITCH_ADDR_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    ola_start,
  input  logic [ADDR_W-1:0]       ola_addr,
  input  logic                    ola_first,
  input  logic                    s_valid,
  input  logic [SAMPLE_W-1:0]     s_data,
  output logic                    s_ready,
  output logic                    ola_busy,
  output logic                    ola_done,
  output logic                    ola_read,
  output logic                    ola_write,
  output logic [ADDR_W-1:0]       ola_address,
  input  logic [SDRAM_DATA_W-1:0] ola_readdata,
  output logic [SDRAM_DATA_W-1:0] ola_writedata,
  input  logic                    ola_sdram_finished
);

  localparam int CNT_W = $clog2(WINDOW_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SIZE - 1);

  ola_state_t                  state_q, state_d;
  logic                        first_q, first_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic signed [SAMPLE_W-1:0]  smp_q, smp_d;
  logic signed [SAMPLE_W-1:0]  lsum_q, lsum_d;
  logic signed [SAMPLE_W-1:0]  rsum_q, rsum_d;
  logic signed [SAMPLE_W-1:0]  rd_left, rd_right;
  logic signed [SAMPLE_W-1:0]  left_sat, right_sat;

  assign rd_left  = ola_readdata[SDRAM_DATA_W-1:SAMPLE_W];
  assign rd_right = ola_readdata[SAMPLE_W-1:0];

  sat_add16 u_sat_left (
    .a_i   (rd_left),
    .b_i   (smp_q),
    .sum_o (left_sat)
  );

  sat_add16 u_sat_right (
    .a_i   (rd_right),
    .b_i   (smp_q),
    .sum_o (right_sat)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    smp_d   = smp_q;
    lsum_d  = lsum_q;
    rsum_d  = rsum_q;
    case (state_q)
      IDLE: begin
        if (ola_start) begin
          first_d = ola_first;
          addr_d  = ola_addr;
          cnt_d   = '0;
          state_d = WAIT_SAMPLE;
        end
      end
      WAIT_SAMPLE: begin
        if (s_valid) begin
          smp_d = s_data;
          // Overwrite frames skip the read and store the sample on both channels.
          if (first_q) begin
            lsum_d  = s_data;
            rsum_d  = s_data;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (ola_sdram_finished) begin
          lsum_d  = left_sat;
          rsum_d  = right_sat;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ola_sdram_finished) begin
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = WAIT_SAMPLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      smp_q   <= '0;
      lsum_q  <= '0;
      rsum_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      smp_q   <= smp_d;
      lsum_q  <= lsum_d;
      rsum_q  <= rsum_d;
    end
  end

  assign s_ready       = (state_q == WAIT_SAMPLE);
  assign ola_busy      = (state_q != IDLE);
  assign ola_done      = (state_q == DONE);
  assign ola_read      = (state_q == READ);
  assign ola_write     = (state_q == WRITE);
  assign ola_address   = addr_q;
  assign ola_writedata = {lsum_q, rsum_q};

endmodule

// File: tb/tb_pitch_ola_writer.sv
// Randomized bench for pitch_ola_writer: SDRAM responder with random service
// times, frame-level overlap-add reference model, and directed corner frames.
module tb_pitch_ola_writer;

  localparam int WS = 4;
  localparam int AW = 23;

  typedef struct {
    bit          wr;
    logic [22:0] a;
    logic [31:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ola_start, ola_first, s_valid, s_ready;
  logic [22:0] ola_addr, ola_address;
  logic [15:0] s_data;
  logic        ola_busy, ola_done, ola_read, ola_write, fin;
  logic [31:0] rdata, ola_writedata;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] sdram_mem[int];
  logic [31:0] ref_mem[int];
  bit          stray_en;
  int          total, bad;
  logic [15:0] smp[WS];

  always #5 clk = ~clk;

  pitch_ola_writer #(.WINDOW_SIZE(WS), .ADDR_W(AW)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .ola_start          (ola_start),
    .ola_addr           (ola_addr),
    .ola_first          (ola_first),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .ola_busy           (ola_busy),
    .ola_done           (ola_done),
    .ola_read           (ola_read),
    .ola_write          (ola_write),
    .ola_address        (ola_address),
    .ola_readdata       (rdata),
    .ola_writedata      (ola_writedata),
    .ola_sdram_finished (fin)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_ref(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    sdram_mem[a] = d;
    ref_mem[a]   = d;
  endtask

  // Reference: the complete SDRAM transaction list one frame must produce.
  task automatic build_expect(input int base, input bit first);
    int          a, l, r, s;
    logic [31:0] old, w;
    exp_q.delete();
    for (int i = 0; i < WS; i++) begin
      a = (base + i) % (1 << AW);
      s = int'($signed(smp[i]));
      if (first) begin
        w = {smp[i], smp[i]};
      end else begin
        old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        exp_q.push_back('{wr: 1'b0, a: 23'(a), d: old});
        l = int'($signed(old[31:16])) + s;
        r = int'($signed(old[15:0])) + s;
        w = {sat_ref(l), sat_ref(r)};
      end
      ref_mem[a] = w;
      exp_q.push_back('{wr: 1'b1, a: 23'(a), d: w});
    end
  endtask

  // SDRAM responder: random 1..20 cycle service, stability checks, stray pulses.
  initial begin
    bit          kind, abort;
    logic [22:0] a;
    logic [31:0] d;
    logic [1:0]  rq;
    int          n;
    fin   = 1'b0;
    rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      fin   = 1'b0;
      rdata = 32'h0;
      if (rst) continue;
      if (ola_read || ola_write) begin
        kind = ola_write;
        a    = ola_address;
        d    = ola_writedata;
        rq   = {ola_read, ola_write};
        check("rw_overlap", 64'(ola_read & ola_write), 64'h0);
        n     = $urandom_range(1, 20);
        abort = 1'b0;
        for (int k = 1; k < n; k++) begin
          @(posedge clk);
          #1;
          if (rst) begin
            abort = 1'b1;
            break;
          end
          check("req_hold", {7'h0, ola_read, ola_write, ola_address, ola_writedata},
                {7'h0, rq, a, d});
        end
        if (!abort) begin
          fin = 1'b1;
          if (kind) begin
            sdram_mem[int'(a)] = d;
            log_q.push_back('{wr: 1'b1, a: a, d: d});
          end else begin
            rdata = sdram_mem.exists(int'(a)) ? sdram_mem[int'(a)] : 32'h0;
            log_q.push_back('{wr: 1'b0, a: a, d: rdata});
          end
        end
      end else if (stray_en && $urandom_range(0, 5) == 0) begin
        fin = 1'b1;
      end
    end
  end

  task automatic run_frame(input string tag, input int base, input bit first);
    int idx, gap, dones, guard;
    bit offered;
    build_expect(base, first);
    log_q.delete();
    @(posedge clk);
    #1;
    ola_start = 1'b1;
    ola_addr  = 23'(base);
    ola_first = first;
    s_valid   = 1'b0;
    idx = 0; offered = 1'b0; dones = 0; guard = 0;
    gap = $urandom_range(0, 2);
    while (dones == 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
      ola_start = 1'b0;
      s_valid   = 1'b0;
      s_data    = 16'h0;
      if (guard == 1) check({tag, "_busy"}, {62'h0, ola_busy, s_ready}, 64'h3);
      if (offered) begin
        check({tag, "_lat"}, {62'h0, ola_read, ola_write}, first ? 64'h1 : 64'h2);
        idx++;
        offered = 1'b0;
      end
      if (ola_done) begin
        dones++;
      end else begin
        if (s_ready && idx < WS) begin
          if (gap > 0) begin
            gap--;
          end else begin
            s_valid = 1'b1;
            s_data  = smp[idx];
            offered = 1'b1;
            gap     = $urandom_range(0, 2);
          end
        end else if (idx < WS && $urandom_range(0, 3) == 0) begin
          s_valid = 1'b1;
          s_data  = 16'($urandom);
        end
        if (ola_busy && $urandom_range(0, 7) == 0) begin
          ola_start = 1'b1;
          ola_addr  = 23'($urandom);
          ola_first = 1'($urandom);
        end
      end
    end
    if (guard >= 3000) check({tag, "_timeout"}, 64'h1, 64'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ola_done) dones++;
    end
    check({tag, "_idle"}, 64'(ola_busy), 64'h0);
    check({tag, "_done_cnt"}, 64'(dones), 64'h1);
    check({tag, "_txn_cnt"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, "_txn"}, {8'h0, log_q[i].wr, log_q[i].a, log_q[i].d},
            {8'h0, exp_q[i].wr, exp_q[i].a, exp_q[i].d});
    end
  endtask

  task automatic rand_samples();
    for (int i = 0; i < WS; i++) smp[i] = 16'($urandom);
  endtask

  initial begin
    bit seen;
    total = 0; bad = 0; stray_en = 1'b0;
    rst = 1'b1;
    ola_start = 1'b0; ola_addr = '0; ola_first = 1'b0;
    s_valid = 1'b0; s_data = '0;
    #2;
    check("reset_outs", {6'h0, s_ready, ola_busy, ola_done, ola_read, ola_write,
                         ola_address, ola_writedata}, 64'h0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    stray_en = 1'b1;

    for (int i = 0; i < WS; i++) smp[i] = 16'(i + 1);
    run_frame("ovw", 32'h100, 1'b1);
    if (log_q.size() == 4) begin
      check("ovw_first", {9'h0, log_q[0].a, log_q[0].d}, {9'h0, 23'h100, 32'h00010001});
      check("ovw_last",  {9'h0, log_q[3].a, log_q[3].d}, {9'h0, 23'h103, 32'h00040004});
    end

    poke(32'h200, 32'h00100020);
    rand_samples();
    smp[0] = 16'h0005;
    run_frame("acc", 32'h200, 1'b0);
    if (log_q.size() > 1) check("acc_word", 64'(log_q[1].d), 64'h00150025);

    poke(32'h300, 32'h7FF08005);
    poke(32'h301, 32'h80050000);
    rand_samples();
    smp[0] = 16'h0020;
    smp[1] = 16'hFFF0;
    run_frame("sat", 32'h300, 1'b0);
    if (log_q.size() > 3) begin
      check("sat_hi", 64'(log_q[1].d), 64'h7FFF8025);
      check("sat_lo", 64'(log_q[3].d), 64'h8000FFF0);
    end

    for (int i = 0; i < WS; i++) poke((32'h7FFFFE + i) % (1 << AW), $urandom);
    rand_samples();
    run_frame("wrap", 32'h7FFFFE, 1'b0);
    if (log_q.size() == 8) begin
      check("wrap_a0", 64'(log_q[0].a), 64'h7FFFFE);
      check("wrap_a2", 64'(log_q[4].a), 64'h000000);
      check("wrap_a3", 64'(log_q[7].a), 64'h000001);
    end

    rand_samples();
    run_frame("olap0", 32'h400, 1'b1);
    rand_samples();
    run_frame("olap1", 32'h402, 1'b0);

    for (int f = 0; f < 6; f++) begin
      rand_samples();
      run_frame("rnd", $urandom_range(32'h1000, 32'h1010), 1'($urandom));
    end

    // Reset while a write request is outstanding.
    @(posedge clk);
    #1;
    ola_start = 1'b1; ola_addr = 23'h600; ola_first = 1'b1;
    @(posedge clk);
    #1;
    ola_start = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      if (ola_write) seen = 1'b1;
    end
    check("rst_write_seen", 64'(seen), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_write", {6'h0, s_ready, ola_busy, ola_done, ola_read, ola_write,
                            ola_address, ola_writedata}, 64'h0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    rand_samples();
    run_frame("post_rst", 32'h700, 1'b0);
    if (log_q.size() > 0) check("post_rst_a0", 64'(log_q[0].a), 64'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pitch_ola_writer.md
Name: pitch_ola_writer

Overview:
- Overlap-add writeback stage directly downstream of PitchCore's windowing path.
- Consumes one Hann-windowed frame of 16-bit signed samples per command.
- For each sample, reads the stereo word at the frame's SDRAM target address, adds the sample to both channels with saturation, and writes the word back.
- Uses the same read/write/finished SDRAM handshake as PitchCore, behind the shared SDRAM mux.

Parameters:
- WINDOW_SIZE, 1024, samples per frame; power of two, 2..4096.
- ADDR_W, 23, SDRAM word-address width.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- ola_start  input  1  one-cycle frame command; sampled only in IDLE
- ola_addr  input  ADDR_W  frame base word address; latched with ola_start
- ola_first  input  1  1 = overwrite, no SDRAM read; latched with ola_start
- s_valid  input  1  windowed sample valid
- s_data  input  16  windowed sample, signed two's complement
- s_ready  output  1  sample accepted when s_valid && s_ready
- ola_busy  output  1  high in every state except IDLE
- ola_done  output  1  one-cycle pulse when the frame's last write finishes
- ola_read  output  1  SDRAM read request, held until finished
- ola_write  output  1  SDRAM write request, held until finished
- ola_address  output  ADDR_W  SDRAM word address
- ola_readdata  input  32  {left[31:16], right[15:0]}, valid in the cycle finished is high
- ola_writedata  output  32  {left, right} write word
- ola_sdram_finished  input  1  one-cycle completion of the current request

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; counter 0; all registers 0.
- Reset mid-transaction: ola_read and ola_write drop asynchronously. No completion is owed to the SDRAM side.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- IDLE:
  - s_ready = 0.
  - On ola_start: latch base = ola_addr and first = ola_first, set cnt = 0, go to WAIT_SAMPLE.
- WAIT_SAMPLE:
  - s_ready = 1.
  - On s_valid: capture s_data into smp.
  - Next state is WRITE if first = 1, otherwise READ.
- READ:
  - ola_read = 1, ola_address = base + cnt, taken modulo 2^ADDR_W (wraps at 0x7FFFFF -> 0).
  - On ola_sdram_finished: lsum = sat16(rd[31:16] + smp) and rsum = sat16(rd[15:0] + smp). Go to WRITE.
- WRITE:
  - ola_write = 1, same address, ola_writedata = {lsum, rsum}.
  - With first = 1, lsum = rsum = smp.
  - On ola_sdram_finished:
    - if cnt == WINDOW_SIZE-1, go to DONE;
    - otherwise cnt++ and go to WAIT_SAMPLE.
- DONE: ola_done = 1 for exactly one cycle, then IDLE.
- sat16: 17-bit signed sum, clamped to +32767 (0x7FFF) or -32768 (0x8000).
- Request stability: ola_read, ola_write, ola_address and ola_writedata stay constant from assertion until the cycle after finished. ola_read and ola_write are never high together.
- Latency:
  - READ is entered the cycle after the sample handshake.
  - Each read-modify-write costs 1 + Tr + Tw cycles (Tr, Tw = SDRAM service times).
  - ola_done rises the cycle after the last write's finished.
- Ignored inputs:
  - ola_start while busy: ignored; base and first are unchanged.
  - ola_sdram_finished in IDLE, WAIT_SAMPLE or DONE: ignored.
  - s_valid outside WAIT_SAMPLE: not accepted (s_ready = 0).
- Back-to-back frames: ola_start in the cycle ola_done is high is ignored. The earliest accepted start is the cycle after, in IDLE.
- Overlap: successive frames with the same base + hop produce the overlap-add result.

Decomposition:
- Shared package PitchDefine (extended):
  - typedef ola_state_t {IDLE, WAIT_SAMPLE, READ, WRITE, DONE};
  - localparams PITCH_ADDR_W = 23, SAMPLE_W = 16, SDRAM_DATA_W = 32, SAT_MAX = 16'sh7FFF, SAT_MIN = 16'sh8000.
- Sub-module sat_add16: combinational 16+16 signed add with clamp, instantiated twice (left and right channels).

Test Plan:
- Overwrite frame, WINDOW_SIZE = 4: ola_first = 1, ola_addr = 0x000100, samples 1, 2, 3, 4.
  - Required: exactly 4 writes to 0x100..0x103 with {0x0001,0x0001}..{0x0004,0x0004}, no ola_read, one ola_done.
- Accumulate frame:
  - Setup: SDRAM holds 0x00100020 at 0x200; ola_first = 0, sample 0x0005.
  - Required: a read of 0x200, then a write of 0x00250025... corrected per channel to {0x0015, 0x0025} (left 0x0010+5, right 0x0020+5).
- Saturation:
  - Read word {0x7FF0, 0x8005} plus sample 0x0020 -> writes {0x7FFF, 0x8025}.
  - Read word {0x8005, 0x0000} plus sample 0xFFF0 (-16) -> writes {0x8000, 0xFFF0}.
- Address wrap: ola_addr = 0x7FFFFE, WINDOW_SIZE = 4 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
- Stalls and protocol:
  - Stimulus: SDRAM finishes after random 1-20 cycles; s_valid randomly gapped; stray ola_start and ola_sdram_finished pulses while idle or waiting.
  - Required: ola_read and ola_write held stable and never overlapping; no extra transactions; stray ola_start ignored.
- Reset mid-WRITE: assert i_rst while ola_write = 1.
  - Required: ola_write = 0 and all outputs 0 immediately.
  - After release, a new frame completes normally with cnt restarting at 0.
